// File: rtl/serial_adder_5b_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_5b_pkg
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
// ---------------------------------------------------------------------------
package serial_adder_5b_pkg;

    localparam int DEFAULT_WIDTH = 5;
    localparam int DEFAULT_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : serial_adder_5b_pkg

// File: rtl/serial_adder_5b_if.sv
// ---------------------------------------------------------------------------
// serial_adder_5b_if
// Operand/result handshake bundle for the bit-serial adder.
//   in_valid / in_ready   : operand handshake (producer -> adder)
//   in_a, in_b, in_c      : operands and carry-in
//   out_valid / out_ready : result handshake (adder -> consumer)
//   out_s, out_c          : sum and carry-out
// modport master : the side that supplies operands and consumes results
// modport slave  : the adder itself
// ---------------------------------------------------------------------------
interface serial_adder_5b_if #(
    parameter int WIDTH = serial_adder_5b_pkg::DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_s;
    logic             out_c;

    modport master (
        output in_valid, in_a, in_b, in_c, out_ready,
        input  in_ready, out_valid, out_s, out_c
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, out_ready,
        output in_ready, out_valid, out_s, out_c
    );
endinterface : serial_adder_5b_if

// File: rtl/serial_adder_5b_full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// One-bit combinational full adder; the single arithmetic cell that the
// serial adder reuses on every SHIFT cycle.
//   in_a, in_b, in_c : addend bits and carry-in
//   out_s            : sum bit
//   out_c            : carry-out (majority of the three inputs)
// ---------------------------------------------------------------------------
module full_adder (
    input  logic in_a,
    input  logic in_b,
    input  logic in_c,
    output logic out_s,
    output logic out_c
);
    assign out_s = in_a ^ in_b ^ in_c;
    assign out_c = (in_a & in_b) | (in_a & in_c) | (in_b & in_c);
endmodule : full_adder

// File: rtl/serial_adder_5b.sv
// ---------------------------------------------------------------------------
// serial_adder_5b
// Bit-serial handshaked adder: accepts {in_a, in_b, in_c}, adds LSB-first
// through one full_adder over WIDTH cycles and presents {out_c, out_s} =
// in_a + in_b + in_c until the consumer takes it.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : operand/result handshake (serial_adder_5b_if.slave)
//   busy    : high while an operation is in SHIFT or DONE
// ---------------------------------------------------------------------------
module serial_adder_5b
    import serial_adder_5b_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,  // >= 1
    parameter int CNT_W = DEFAULT_CNT_W   // 2**CNT_W > WIDTH
) (
    input  logic                clk,
    input  logic                reset_n,
    serial_adder_5b_if.slave    bus,
    output logic                busy
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum_sh;
    logic               r_carry;

    logic               w_s;
    logic               w_co;
    logic               w_last;

    full_adder u_full_adder (
        .in_a  (r_a_sh[0]),
        .in_b  (r_b_sh[0]),
        .in_c  (r_carry),
        .out_s (w_s),
        .out_c (w_co)
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; the adder cell reads r_carry/r_a_sh[0]
    // while the same edge updates them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the datapath registers are reset too, so a reset during an
            // operation leaves out_s/out_c at zero rather than a partial sum.
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a_sh   <= bus.in_a;
                        r_b_sh   <= bus.in_b;
                        r_carry  <= bus.in_c;
                        r_sum_sh <= '0;
                        r_cnt    <= '0;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_carry  <= w_co;
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    // New sum bit enters at the MSB; after WIDTH shifts the
                    // first (LSB) result bit has reached position 0.
                    r_sum_sh <= (r_sum_sh >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Handshake flags decode straight from the registered state.
    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign busy          = (r_state != IDLE);
    assign bus.out_s     = r_sum_sh;
    assign bus.out_c     = r_carry;

endmodule : serial_adder_5b
